// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer
//   Command stage in front of a synchronous-reset SR flip-flop. It accepts
//   set/reset/toggle commands on a valid/ready handshake and turns each one
//   into a clean s or r pulse of HOLD_CYC cycles. It never drives s and r
//   high together. It keeps its own model of the flip-flop state (exp_q),
//   compares q_fb against that model once per command, and counts the set
//   and reset drives it has issued.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   cmd_valid  command present
//   cmd_op     00 NOP, 01 RESET, 10 SET, 11 TOGGLE
//   cmd_ready  high while idle (decoded from state)
//   s, r       registered set/reset drives to the flip-flop
//   q_fb       q returned from the flip-flop
//   busy       high while a command is in flight
//   exp_q      registered expected flip-flop state
//   mismatch   one-cycle pulse, the cycle after CHECK, when q_fb != exp_q
//   set_cnt    SET drives issued, saturating
//   rst_cnt    RESET drives issued, saturating
module sr_drive_sequencer #(
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned GAP_CYC  = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    output logic             busy,
    output logic             exp_q,
    output logic             mismatch,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] rst_cnt
);

    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("sr_drive_sequencer: HOLD_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, GAP} state_t;
    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    // One counter serves both the DRIVE hold time and the GAP time.
    localparam int unsigned MAX_PH = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned TW     = (MAX_PH < 2) ? 1 : $clog2(MAX_PH + 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);

    state_t          state, next_state;
    logic [TW-1:0]   phase_cnt;
    logic            drive_set;      // current DRIVE is an s pulse (else r)

    op_t             op;
    logic            accept, want_set, want_rst, start;

    logic            s_d, r_d, exp_q_d, mismatch_d, drive_set_d;
    logic [CNT_W-1:0] set_cnt_d, rst_cnt_d;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // TOGGLE resolves against the model, not against q_fb.
    assign op       = op_t'(cmd_op);
    assign accept   = cmd_valid & cmd_ready;
    assign want_set = (op == OP_SET)   | ((op == OP_TOGGLE) & ~exp_q);
    assign want_rst = (op == OP_RESET) | ((op == OP_TOGGLE) &  exp_q);
    assign start    = accept & (want_set | want_rst);

    // State register and phase counter.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would chain registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
        end else begin
            state     <= next_state;
            phase_cnt <= (next_state != state) ? '0 : phase_cnt + 1'b1;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment at the top keeps this block purely
    // combinational; a path that leaves next_state unassigned infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (start) next_state = DRIVE;
            DRIVE: if (phase_cnt == HOLD_LAST) next_state = CHECK;
            CHECK: next_state = (GAP_CYC == 0) ? IDLE : GAP;
            GAP:   if (phase_cnt == GAP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        s_d         = 1'b0;
        r_d         = 1'b0;
        mismatch_d  = 1'b0;
        exp_q_d     = exp_q;
        drive_set_d = drive_set;
        set_cnt_d   = set_cnt;
        rst_cnt_d   = rst_cnt;

        if (start) begin
            drive_set_d = want_set;
            s_d         = want_set;
            r_d         = want_rst;
            exp_q_d     = want_set;
            if (want_set && set_cnt != '1) set_cnt_d = set_cnt + 1'b1;
            if (want_rst && rst_cnt != '1) rst_cnt_d = rst_cnt + 1'b1;
        end

        // Hold the pulse until the last DRIVE cycle; s and r are decoded
        // from a single flag, so they can never both be high.
        if (state == DRIVE && next_state == DRIVE) begin
            s_d = drive_set;
            r_d = ~drive_set;
        end

        if (state == CHECK) mismatch_d = q_fb ^ exp_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s         <= 1'b0;
            r         <= 1'b0;
            exp_q     <= 1'b0;
            mismatch  <= 1'b0;
            drive_set <= 1'b0;
            set_cnt   <= '0;
            rst_cnt   <= '0;
        end else begin
            s         <= s_d;
            r         <= r_d;
            exp_q     <= exp_q_d;
            mismatch  <= mismatch_d;
            drive_set <= drive_set_d;
            set_cnt   <= set_cnt_d;
            rst_cnt   <= rst_cnt_d;
        end
    end

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Testbench for sr_drive_sequencer with HOLD_CYC=2, GAP_CYC=1, CNT_W=8.
// Commands push an expected record to a scoreboard when accepted; a monitor
// pops it when the s/r pulse appears and checks pulse timing, kind, model
// state, counters, the mismatch slot and the return of cmd_ready.
module tb_sr_drive_sequencer;

    localparam int HOLD_CYC = 2;
    localparam int GAP_CYC  = 1;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic             cmd_ready;
    logic             s, r;
    logic             q_fb;
    logic             busy;
    logic             exp_q;
    logic             mismatch;
    logic [CNT_W-1:0] set_cnt, rst_cnt;

    sr_drive_sequencer #(
        .HOLD_CYC(HOLD_CYC),
        .GAP_CYC (GAP_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_ready(cmd_ready),
        .s        (s),
        .r        (r),
        .q_fb     (q_fb),
        .busy     (busy),
        .exp_q    (exp_q),
        .mismatch (mismatch),
        .set_cnt  (set_cnt),
        .rst_cnt  (rst_cnt)
    );

    always #5 clk = ~clk;

    // Downstream sync-reset SR flip-flop; tie_low forces a stuck-at-0 q_fb.
    logic ff_q = 1'b0;
    logic tie_low = 1'b0;
    always @(posedge clk) begin
        if (reset)  ff_q <= 1'b0;
        else if (s) ff_q <= 1'b1;
        else if (r) ff_q <= 1'b0;
    end
    assign q_fb = tie_low ? 1'b0 : ff_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    typedef struct {
        int acc;
        bit is_set;
        bit exp_q;
        bit mm;
        int set_cnt;
        int rst_cnt;
    } item_t;

    item_t sb[$];

    // Reference model of the expected state and counters.
    bit m_exp_q = 0;
    int m_set = 0;
    int m_rst = 0;
    int mm_expected = 0;
    int mm_seen = 0;
    bit overlap = 0;

    // Monitor
    item_t act;
    bit    act_valid = 0;
    int    start_cyc = 0;
    bit    prev_sr = 0;

    always @(negedge clk) begin
        if (s && r) overlap = 1;
        if (mismatch) mm_seen++;
        if (reset) begin
            sb.delete();
            act_valid = 0;
        end else begin
            if ((s || r) && !prev_sr) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    act = sb.pop_front();
                    act_valid = 1;
                    start_cyc = cyc;
                    check("pulse_start", cyc, act.acc + 1);
                    check("pulse_is_set", s, act.is_set);
                    check("exp_q", exp_q, act.exp_q);
                    check("set_cnt", set_cnt, act.set_cnt);
                    check("rst_cnt", rst_cnt, act.rst_cnt);
                end
            end
            if (!(s || r) && prev_sr && act_valid)
                check("pulse_len", cyc - start_cyc, HOLD_CYC);
            if (act_valid && cyc == act.acc + HOLD_CYC + 2)
                check("mismatch", mismatch, act.mm);
            if (act_valid && cyc == act.acc + HOLD_CYC + GAP_CYC + 1)
                check("ready_low", cmd_ready, 0);
            if (act_valid && cyc == act.acc + HOLD_CYC + GAP_CYC + 2) begin
                check("ready_high", cmd_ready, 1);
                act_valid = 0;
            end
        end
        prev_sr = s | r;
    end

    // Present a command and hold it until accepted; ends just after the
    // accept edge.
    task automatic send(input logic [1:0] op);
        item_t it;
        bit ok = 0;
        bit ws;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end else if (op != OP_NOP) begin
            ws = (op == OP_SET) || (op == OP_TOGGLE && !m_exp_q);
            m_exp_q = ws;
            if (ws && m_set < CNT_MAX) m_set++;
            if (!ws && m_rst < CNT_MAX) m_rst++;
            it.acc     = cyc;
            it.is_set  = ws;
            it.exp_q   = m_exp_q;
            it.mm      = tie_low ? m_exp_q : 1'b0;
            it.set_cnt = m_set;
            it.rst_cnt = m_rst;
            if (it.mm) mm_expected++;
            sb.push_back(it);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic wait_quiet();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready && !act_valid && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("quiet_timeout", 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_s", s, 0);
        check("rst_r", r, 0);
        check("rst_exp_q", exp_q, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_set_cnt", set_cnt, 0);
        check("rst_rst_cnt", rst_cnt, 0);

        // 2: SET with q_fb following the flip-flop
        send(OP_SET);
        wait_quiet();

        // 3: TOGGLE from exp_q=1 -> RESET, then TOGGLE -> SET
        send(OP_TOGGLE);
        send(OP_TOGGLE);
        wait_quiet();
        check("toggle_exp_q", exp_q, 1);

        // 4: SET with q_fb stuck at 0
        tie_low = 1'b1;
        send(OP_SET);
        wait_quiet();
        tie_low = 1'b0;
        check("stuck_exp_q", exp_q, 1);

        // 5: reset in the first DRIVE cycle
        send(OP_SET);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_exp_q = 0;
        m_set = 0;
        m_rst = 0;
        @(negedge clk);
        check("abort_s", s, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_exp_q", exp_q, 0);
        check("abort_set_cnt", set_cnt, 0);
        check("abort_rst_cnt", rst_cnt, 0);

        // 6a: NOP is consumed without effect
        send(OP_SET);
        wait_quiet();
        send(OP_NOP);
        repeat (4) @(negedge clk);
        check("nop_exp_q", exp_q, 1);
        check("nop_ready", cmd_ready, 1);
        check("nop_set_cnt", set_cnt, 1);

        // 6b: cmd_valid pulses while busy are ignored
        send(OP_SET);
        cmd_valid = 1'b1;
        cmd_op    = OP_RESET;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = OP_TOGGLE;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        wait_quiet();
        check("busy_rst_cnt", rst_cnt, 0);

        // 6c: counter saturation
        for (int i = 0; i < (1 << CNT_W) + 1; i++) send(OP_SET);
        wait_quiet();
        check("sat_set_cnt", set_cnt, CNT_MAX);
        check("sat_rst_cnt", rst_cnt, 0);

        check("s_r_exclusive", overlap, 0);
        check("mismatch_pulses", mm_seen, mm_expected);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
